// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode constants: ALU operation codes, main-decoder ALU classes,
// opcode patterns and the ALU-control pipeline state encoding.
package legv8_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_LSL   = 4'b0011;
    localparam logic [3:0] ALU_LSR   = 4'b0100;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_MUL   = 4'b1000;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_CB  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;

    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_AND = 11'b10001010000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;
    localparam logic [10:0] OP_LSL = 11'b11010011011;
    localparam logic [10:0] OP_LSR = 11'b11010011010;
    localparam logic [10:0] OP_MUL = 11'b10011011000;
    // Immediate forms ignore the lowest opcode bit (it belongs to the immediate)
    localparam logic [9:0]  OP_ADDI_HI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI_HI = 10'b1101000100;
    localparam logic [7:0]  OP_CBZ     = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ    = 8'b10110101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        WAIT = 2'd2
    } aludec_state_t;

endpackage

// File: rtl/aludec_core.sv
// Pure combinational ALU-control decode: (aluop, funct) -> operation code,
// multicycle flag for MUL and illegal flag for unmatched encodings.
module aludec_core #(
    parameter int FUNCT_W  = 11,
    parameter int ALUCTL_W = 4
) (
    input  logic [1:0]          aluop,
    input  logic [FUNCT_W-1:0]  funct,
    output logic [ALUCTL_W-1:0] code,
    output logic                multicycle,
    output logic                illegal
);
    import legv8_pkg::*;

    logic [10:0] op_s;
    logic [3:0]  code_s;

    assign op_s = funct[FUNCT_W-1 -: 11];
    assign code = ALUCTL_W'(code_s);

    // Opcode match for each ALU class
    always_comb begin
        code_s     = ALU_AND;
        multicycle = 1'b0;
        illegal    = 1'b0;
        case (aluop)
            ALUOP_MEM: begin
                code_s = ALU_ADD;
            end
            ALUOP_CB: begin
                code_s = ALU_PASSB;
                if ((op_s[10:3] == OP_CBZ) || (op_s[10:3] == OP_CBNZ)) begin
                    illegal = 1'b0;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: begin
                if (op_s == OP_ADD) begin
                    code_s = ALU_ADD;
                end else if (op_s == OP_SUB) begin
                    code_s = ALU_SUB;
                end else if (op_s == OP_AND) begin
                    code_s = ALU_AND;
                end else if (op_s == OP_ORR) begin
                    code_s = ALU_ORR;
                end else if (op_s[10:1] == OP_ADDI_HI) begin
                    code_s = ALU_ADD;
                end else if (op_s[10:1] == OP_SUBI_HI) begin
                    code_s = ALU_SUB;
                end else if (op_s == OP_LSL) begin
                    code_s = ALU_LSL;
                end else if (op_s == OP_LSR) begin
                    code_s = ALU_LSR;
                end else if (op_s == OP_MUL) begin
                    code_s     = ALU_MUL;
                    multicycle = 1'b1;
                end else begin
                    code_s  = ALU_AND;
                    illegal = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/aludec_pipe.sv
// Registered, handshaked ALU-control stage between ID/EX and the ALU. Holds the
// decoded op under back-pressure, supports flush and models multiplier latency.
module aludec_pipe #(
    parameter int FUNCT_W  = 11,
    parameter int ALUCTL_W = 4,
    parameter int MUL_LAT  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic [1:0]          aluop,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ALUCTL_W-1:0] alucontrol,
    output logic                multicycle,
    output logic                illegal
);
    import legv8_pkg::*;

    localparam int               CNT_W    = $clog2(MUL_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic             MUL_WAIT = (MUL_LAT > 1);

    aludec_state_t       state_r, state_nx_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nx_s;
    logic [ALUCTL_W-1:0] dec_code_s, code_r;
    logic                dec_mc_s, dec_ill_s, mc_r, ill_r;
    logic                in_ready_s, accept_s, out_valid_r;

    aludec_core #(
        .FUNCT_W  (FUNCT_W),
        .ALUCTL_W (ALUCTL_W)
    ) u_core (
        .aluop      (aluop),
        .funct      (funct),
        .code       (dec_code_s),
        .multicycle (dec_mc_s),
        .illegal    (dec_ill_s)
    );

    // Upstream ready: empty, or the held op leaves this cycle; never during flush
    always_comb begin
        in_ready_s = 1'b0;
        if (flush) begin
            in_ready_s = 1'b0;
        end else if (state_r == IDLE) begin
            in_ready_s = 1'b1;
        end else if (state_r == HOLD) begin
            in_ready_s = out_ready;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign accept_s   = in_valid & in_ready_s;
    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign alucontrol = code_r;
    assign multicycle = mc_r;
    assign illegal    = ill_r;

    // Next-state and latency counter
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        if (flush) begin
            state_nx_s = IDLE;
            cnt_nx_s   = '0;
        end else begin
            case (state_r)
                IDLE, HOLD: begin
                    if (accept_s) begin
                        // A MUL parks in WAIT so out_valid rises MUL_LAT cycles after accept
                        if (dec_mc_s && MUL_WAIT) begin
                            state_nx_s = WAIT;
                            cnt_nx_s   = CNT_LOAD;
                        end else begin
                            state_nx_s = HOLD;
                            cnt_nx_s   = '0;
                        end
                    end else if ((state_r == HOLD) && !out_ready) begin
                        state_nx_s = HOLD;
                        cnt_nx_s   = '0;
                    end else begin
                        state_nx_s = IDLE;
                        cnt_nx_s   = '0;
                    end
                end
                WAIT: begin
                    if (cnt_r <= CNT_W'(1)) begin
                        state_nx_s = HOLD;
                        cnt_nx_s   = '0;
                    end else begin
                        state_nx_s = WAIT;
                        cnt_nx_s   = cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                    cnt_nx_s   = '0;
                end
            endcase
        end
    end

    // State, counter and output-valid registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            out_valid_r <= (state_nx_s == HOLD);
        end
    end

    // Decoded result captured only on accept, held otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            code_r <= '0;
            mc_r   <= 1'b0;
            ill_r  <= 1'b0;
        end else if (accept_s) begin
            code_r <= dec_code_s;
            mc_r   <= dec_mc_s;
            ill_r  <= dec_ill_s;
        end else begin
            code_r <= code_r;
            mc_r   <= mc_r;
            ill_r  <= ill_r;
        end
    end

endmodule

// File: doc/aludec_pipe.md
Name: aludec_pipe

Overview:
- Registered, handshaked ALU control decoder for the pipelined LEGv8 core. It sits between the ID/EX pipeline register and the ALU.
- Decodes (aluop, funct) into alucontrol and adds decodes for SUBI, LSL, LSR and MUL.
- Holds results under back-pressure and supports flush.
- Models the occupancy of the multi-cycle multiplier: a MUL result is held back for MUL_LAT cycles before it is presented.

Parameters:
- FUNCT_W, 11, opcode/funct field width; must be >= 11. Decode uses the top 11 bits.
- ALUCTL_W, 4, alucontrol width; must be >= 4. Codes are zero-extended.
- MUL_LAT, 4, cycles from MUL acceptance to out_valid; legal range 1..16.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- in_valid  in  1  upstream has an op
- in_ready  out  1  block can accept
- funct  in  FUNCT_W  instruction opcode field
- aluop  in  2  main decoder ALU class
- flush  in  1  discard held/pending op (branch mispredict)
- out_valid  out  1  alucontrol valid
- out_ready  in  1  downstream consumes
- alucontrol  out  ALUCTL_W  ALU operation code
- multicycle  out  1  held op is MUL
- illegal  out  1  held op did not match any decode

Behaviour:
- Reset: clk is the only clock; reset is asynchronous and active-low.
  - While reset=0: state=IDLE, out_valid=0, alucontrol=0, multicycle=0, illegal=0, counter=0.
  - Reset asserted mid-operation abandons the op immediately.
- Decode (combinational, registered on accept):
  - aluop=00 -> 0010
  - aluop=01:
    - funct[10:3]=10110100 (CBZ) or 10110101 (CBNZ) -> 0111
    - otherwise 0111 with illegal=1
  - aluop=1x:
    - ADD 10001011000 -> 0010
    - SUB 11001011000 -> 0110
    - AND 10001010000 -> 0000
    - ORR 10101010000 -> 0001
    - ADDI 1001000100x -> 0010
    - SUBI 1101000100x -> 0110
    - LSL 11010011011 -> 0011
    - LSR 11010011010 -> 0100
    - MUL 10011011000 -> 1000 with multicycle=1
    - anything else -> 0000 with illegal=1
- Accept = in_valid & in_ready. in_ready = !flush & (state==IDLE | (state==HOLD & out_ready)).
- FSM states IDLE, HOLD, WAIT:
  - IDLE, accept non-MUL -> HOLD. out_valid=1 the next cycle (latency 1).
  - IDLE, accept MUL:
    - MUL_LAT=1 -> HOLD.
    - MUL_LAT>1 -> WAIT with counter=MUL_LAT-1.
  - WAIT: counter decrements each cycle; out_valid=0; in_ready=0. When counter reaches 1 -> HOLD, so out_valid rises exactly MUL_LAT cycles after accept.
  - HOLD, out_ready=0: outputs stable, no accept.
  - HOLD, out_ready=1 and accept: back-to-back. The new op is loaded the same edge (HOLD or WAIT per decode), so there is no bubble for non-MUL ops.
  - HOLD, out_ready=1 and no accept -> IDLE, out_valid=0.
- flush=1 in any state: the next state is IDLE, out_valid=0, counter=0. The held op is dropped even if out_ready=1 in that cycle. in_ready=0, so a simultaneous input is not taken.
- alucontrol, multicycle and illegal only change on accept. Outside HOLD they hold their last value.
- Counter width is clog2(MUL_LAT+1). The counter never wraps: it saturates at 0 in IDLE/HOLD.

Decomposition:
- Package legv8_pkg holds:
  - alucontrol code constants: ALU_AND, ALU_ORR, ALU_ADD, ALU_LSL, ALU_LSR, ALU_SUB, ALU_PASSB, ALU_MUL
  - aluop constants: ALUOP_MEM, ALUOP_CB, ALUOP_R
  - opcode pattern constants
  - state enum aludec_state_t {IDLE, HOLD, WAIT}
- One sub-module, aludec_core: the pure combinational decode (aluop, funct -> code, multicycle, illegal). The FSM/register stage lives in aludec_pipe.

Test Plan:
- Reset release, then ADD (aluop=10, funct=10001011000) with in_valid=1, out_ready=1 -> the next cycle out_valid=1, alucontrol=0010, illegal=0.
- Stream SUB, AND, ORR, LSL on consecutive cycles with out_ready=1 -> alucontrol 0110, 0000, 0001, 0011 on consecutive cycles, in_ready always 1.
- MUL accepted, MUL_LAT=4 -> out_valid=0 for 3 cycles, rises on cycle 4 with alucontrol=1000 and multicycle=1; in_ready=0 during WAIT.
- HOLD with out_ready=0 for 5 cycles, then 1 -> ADD stays at 0010, in_ready=0 throughout, released on the first out_ready=1 cycle.
- flush during WAIT, and flush in HOLD with out_ready=1 and in_valid=1 -> next cycle out_valid=0, state IDLE, input not accepted.
- aluop=10 with funct=11111111111, and aluop=01 with funct=10110110000 -> alucontrol 0000 with illegal=1, and 0111 with illegal=1. Assert reset mid-WAIT -> outputs go to 0 asynchronously.
